rs_bank: RTL and testbench
==========================

// Module: rs_bank
// PURPOSE
//  Parametrised multi-entry reservation station for the Tomasulo core; successor to the single-entry add/sub station.
//  Accepts issued ops with operand values or producer tags, snoops the CDB for missing operands, and dispatches
//  ready ops to one functional unit. Each entry is freed when its own result appears on the CDB.
// PARAMETERS
//  N_ENTRIES   3   number of station entries (1..8)
//  DATA_W      16  operand/result width
//  TAG_W       4   tag width; tag 0 = "value present"
//  OP_W        3   opcode width
//  BASE_TAG    1   tag of entry 0; entry i owns tag BASE_TAG+i (BASE_TAG+N_ENTRIES-1 < 2**TAG_W required)
// PORTS
//  CLK         in   1        clock, rising edge
//  CLR         in   1        synchronous active-high reset
//  issue_valid in   1        issue request this cycle
//  issue_op    in   OP_W     opcode (OP_ADD=3'b001, OP_SUB=3'b010)
//  issue_vj    in   DATA_W   operand j value (valid when issue_qj==0)
//  issue_qj    in   TAG_W    producer tag of j, 0 if value present
//  issue_vk    in   DATA_W   operand k value
//  issue_qk    in   TAG_W    producer tag of k
//  issue_tag   out  TAG_W    tag the accepted op will own (combinational, lowest free entry)
//  full        out  1        no free entry; issue ignored while high
//  count       out  4        occupied entries
//  cdb_valid   in   1        CDB broadcast valid
//  cdb_tag     in   TAG_W    broadcasting producer tag
//  cdb_data    in   DATA_W   broadcast value
//  disp_valid  out  1        an entry is ready to execute
//  disp_ready  in   1        FU accepts dispatch
//  disp_op     out  OP_W     opcode of selected entry
//  disp_vj     out  DATA_W   operand j
//  disp_vk     out  DATA_W   operand k
//  disp_tag    out  TAG_W    tag of selected entry (FU returns it on CDB)
// BEHAVIOUR
//  - Entry states: FREE -> WAIT (operand tag pending) | READY -> EXEC -> FREE. All state updates on CLK rising edge.
//  - CLR: all entries FREE, op/V/Q zero; full=0, count=0, disp_valid=0, disp_* =0, issue_tag=BASE_TAG. Mid-operation CLR
//    discards all entries; nothing dispatched that cycle.
//  - Issue: issue_valid && !full writes lowest-index FREE entry; state READY if both Q==0 after capture, else WAIT.
//  - Issue/CDB bypass: if cdb_valid and cdb_tag equals a nonzero issue_qj/qk in the same cycle, cdb_data is stored and Q=0.
//  - CDB snoop: every WAIT entry with Qj or Qk == cdb_tag (nonzero) captures cdb_data and clears that Q; both may match.
//    WAIT becomes READY the cycle after the last Q clears (no same-cycle dispatch of a just-woken entry).
//  - Dispatch: disp_* combinational from registered state; disp_valid = any READY. Handshake disp_valid&&disp_ready
//    moves the selected entry to EXEC. Selection stable while disp_valid&&!disp_ready unless an older entry becomes READY.
//  - Free: EXEC entry whose own tag == cdb_tag with cdb_valid goes FREE. Own-tag broadcast in WAIT/READY/FREE ignored.
//  - full/count from registered state: an entry freed this cycle is reusable next cycle only.
//  - Simultaneous issue+dispatch+free in one cycle all take effect independently. cdb_tag==0 never matches.
//  - Ops other than OP_ADD/OP_SUB are accepted and passed through unchanged.
// CONFIGURATION
//  RS_OLDEST_FIRST_EN defined: per-entry age counter (log2 N_ENTRIES+1 bits); dispatch selects the oldest READY entry;
//   ages of younger entries decrement when an entry frees.
//  Not defined: dispatch selects lowest-index READY entry; no age state.
// STRUCTURE
//  tomasulo_pkg: TAG_W, DATA_W, OP_W defaults, OP_ADD/OP_SUB constants, entry-state enum, TAG_NONE=0.
//  Sub-module rs_entry: one entry's state, operand capture and CDB compare; rs_bank instantiates N_ENTRIES of them plus
//  free-slot priority encoder, dispatch selector and count.
// TESTING
//  1 Issue ADD vj=5,vk=7,q=0 at reset -> issue_tag=1, next cycle disp_valid=1, disp_vj=5, disp_vk=7, disp_tag=1.
//  2 Issue with qj=9; CDB tag 9 data 0x1234 two cycles later -> disp_valid 1 cycle after CDB, disp_vj=0x1234.
//  3 Issue qj=9 while cdb_tag=9 same cycle -> bypass captured, READY next cycle, disp_vj=cdb_data.
//  4 Fill 3 entries (disp_ready=0) -> full=1, count=3, 4th issue ignored; dispatch entry 2 then CDB tag 3 -> full=0 next cycle.
//  5 Entries 2 then 0 become READY (OLDEST_FIRST_EN) -> entry 2 (tag 3) dispatched first; without macro tag 1 first.
//  6 CLR asserted with 2 entries WAIT/EXEC -> next cycle count=0, disp_valid=0, later CDB matching old tags has no effect.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core reservation stations.
// Contents: default widths, opcode constants, the reservation-station
// entry state type and the "value present" tag.
package tomasulo_pkg;

    localparam int unsigned RS_TAG_W  = 4;
    localparam int unsigned RS_DATA_W = 16;
    localparam int unsigned RS_OP_W   = 3;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    // Tag value meaning "operand value already present"
    localparam int unsigned TAG_NONE = 0;

    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: holds opcode, operand values and producer
// tags, captures operands from the issue port (with CDB bypass) or by
// snooping the CDB, and frees itself when its own tag is broadcast.
// Ports:
//   CLK, CLR                 clock, synchronous active-high reset
//   alloc                    write issue data into this (FREE) entry
//   issue_op/vj/qj/vk/qk     issue payload
//   cdb_valid/tag/data       common data bus
//   grant                    dispatch handshake selected this entry
//   own_tag                  tag this entry owns (nonzero)
//   state, op, vj, vk        registered entry contents
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int unsigned DATA_W = RS_DATA_W,
    parameter int unsigned TAG_W  = RS_TAG_W,
    parameter int unsigned OP_W   = RS_OP_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              alloc,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              grant,
    input  logic [TAG_W-1:0]  own_tag,
    output rs_state_t         state,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    logic [TAG_W-1:0] qj, qk;
    logic             cdb_live;
    logic             byp_j, byp_k, snp_j, snp_k, own_hit;

    always_comb begin
        cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
        byp_j    = cdb_live && (issue_qj == cdb_tag);
        byp_k    = cdb_live && (issue_qk == cdb_tag);
        snp_j    = cdb_live && (qj == cdb_tag);
        snp_k    = cdb_live && (qk == cdb_tag);
        own_hit  = cdb_live && (own_tag == cdb_tag);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= RS_FREE;
            op    <= '0;
            vj    <= '0;
            vk    <= '0;
            qj    <= '0;
            qk    <= '0;
        end else begin
            case (state)
                RS_FREE: begin
                    if (alloc) begin
                        op <= issue_op;
                        vj <= byp_j ? cdb_data : issue_vj;
                        qj <= byp_j ? '0 : issue_qj;
                        vk <= byp_k ? cdb_data : issue_vk;
                        qk <= byp_k ? '0 : issue_qk;
                        state <= ((byp_j || issue_qj == '0) && (byp_k || issue_qk == '0))
                                 ? RS_READY : RS_WAIT;
                    end
                end
                RS_WAIT: begin
                    if (snp_j) begin
                        vj <= cdb_data;
                        qj <= '0;
                    end
                    if (snp_k) begin
                        vk <= cdb_data;
                        qk <= '0;
                    end
                    if ((snp_j || qj == '0) && (snp_k || qk == '0))
                        state <= RS_READY;
                end
                RS_READY: begin
                    if (grant)
                        state <= RS_EXEC;
                end
                RS_EXEC: begin
                    if (own_hit)
                        state <= RS_FREE;
                end
                default: state <= RS_FREE;
            endcase
        end
    end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: issues into the lowest free entry,
// snoops the CDB for missing operands, dispatches one ready op to a
// functional unit and frees each entry when its own tag is broadcast.
// Configuration macro: RS_OLDEST_FIRST_EN -- dispatch the oldest ready
// entry (per-entry age counters) instead of the lowest-index ready entry.
// Ports:
//   CLK, CLR                          clock, synchronous active-high reset
//   issue_valid/op/vj/qj/vk/qk        issue request and payload
//   issue_tag                         tag the next accepted op will own
//   full, count                       occupancy (registered state)
//   cdb_valid/tag/data                common data bus
//   disp_valid/ready/op/vj/vk/tag     dispatch handshake to the FU
module rs_bank
    import tomasulo_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 3,
    parameter int unsigned DATA_W    = RS_DATA_W,
    parameter int unsigned TAG_W     = RS_TAG_W,
    parameter int unsigned OP_W      = RS_OP_W,
    parameter int unsigned BASE_TAG  = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              full,
    output logic [3:0]        count,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [OP_W-1:0]   disp_op,
    output logic [DATA_W-1:0] disp_vj,
    output logic [DATA_W-1:0] disp_vk,
    output logic [TAG_W-1:0]  disp_tag
);

    localparam int unsigned IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    rs_state_t         st     [N_ENTRIES];
    logic [OP_W-1:0]   e_op   [N_ENTRIES];
    logic [DATA_W-1:0] e_vj   [N_ENTRIES];
    logic [DATA_W-1:0] e_vk   [N_ENTRIES];
    logic [TAG_W-1:0]  own_tag[N_ENTRIES];
    logic [N_ENTRIES-1:0] alloc, grant;

    logic             free_found, sel_found;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic [3:0]       cnt;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
        assign own_tag[g] = TAG_W'(BASE_TAG + g);

        rs_entry #(
            .DATA_W(DATA_W),
            .TAG_W (TAG_W),
            .OP_W  (OP_W)
        ) u_entry (
            .CLK      (CLK),
            .CLR      (CLR),
            .alloc    (alloc[g]),
            .issue_op (issue_op),
            .issue_vj (issue_vj),
            .issue_qj (issue_qj),
            .issue_vk (issue_vk),
            .issue_qk (issue_qk),
            .cdb_valid(cdb_valid),
            .cdb_tag  (cdb_tag),
            .cdb_data (cdb_data),
            .grant    (grant[g]),
            .own_tag  (own_tag[g]),
            .state    (st[g]),
            .op       (e_op[g]),
            .vj       (e_vj[g]),
            .vk       (e_vk[g])
        );
    end

    // Lowest free slot and occupancy, both from registered state so a slot
    // freed this cycle becomes visible next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cnt        = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (st[i] == RS_FREE) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end else begin
                cnt = cnt + 4'd1;
            end
        end
    end

    assign count     = cnt;
    assign full      = !free_found;
    assign issue_tag = TAG_W'(BASE_TAG) + TAG_W'(free_idx);

`ifdef RS_OLDEST_FIRST_EN
    localparam int unsigned AGE_W = $clog2(N_ENTRIES) + 1;

    // age = number of older live entries; 0 is the oldest.
    logic [AGE_W-1:0] age [N_ENTRIES];
    logic             free_any;
    logic [AGE_W-1:0] free_age;
    logic [AGE_W-1:0] sel_age;

    always_comb begin
        free_any = 1'b0;
        free_age = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (st[i] == RS_EXEC && cdb_valid && cdb_tag != TAG_W'(TAG_NONE)
                && cdb_tag == own_tag[i]) begin
                free_any = 1'b1;
                free_age = age[i];
            end
        end
    end

    // A new entry is older than nobody: its age is the live count after
    // this cycle's free, which can only be a different slot.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                if (alloc[i])
                    age[i] <= AGE_W'(cnt) - AGE_W'(free_any);
                else if (free_any && st[i] != RS_FREE && age[i] > free_age)
                    age[i] <= age[i] - 1'b1;
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (st[i] == RS_READY && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (st[i] == RS_READY && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        alloc = '0;
        grant = '0;
        if (issue_valid && free_found)
            alloc[free_idx] = 1'b1;
        if (sel_found && disp_ready)
            grant[sel_idx] = 1'b1;
    end

    assign disp_valid = sel_found;
    assign disp_op    = sel_found ? e_op[sel_idx] : '0;
    assign disp_vj    = sel_found ? e_vj[sel_idx] : '0;
    assign disp_vk    = sel_found ? e_vk[sel_idx] : '0;
    assign disp_tag   = sel_found ? own_tag[sel_idx] : '0;

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed scenarios followed by random
// issue/CDB/dispatch traffic, all compared against an entry-list model.
module tb_rs_bank;

    localparam int N    = 3;
    localparam int BASE = 1;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [15:0] issue_vj, issue_vk;
    logic [3:0]  issue_qj, issue_qk;
    logic [3:0]  issue_tag;
    logic        full;
    logic [3:0]  count;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        disp_valid, disp_ready;
    logic [2:0]  disp_op;
    logic [15:0] disp_vj, disp_vk;
    logic [3:0]  disp_tag;

    int errors = 0;
    int checks = 0;

    rs_bank #(
        .N_ENTRIES(N),
        .DATA_W   (16),
        .TAG_W    (4),
        .OP_W     (3),
        .BASE_TAG (BASE)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_vj   (issue_vj),
        .issue_qj   (issue_qj),
        .issue_vk   (issue_vk),
        .issue_qk   (issue_qk),
        .issue_tag  (issue_tag),
        .full       (full),
        .count      (count),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_op    (disp_op),
        .disp_vj    (disp_vj),
        .disp_vk    (disp_vk),
        .disp_tag   (disp_tag)
    );

    always #5 CLK = ~CLK;

    // Model: per-slot occupancy record plus an issue sequence number.
    // m_st: 0 empty, 1 waiting on operands, 2 ready, 3 executing.
    int          m_st [N];
    logic [2:0]  m_op [N];
    logic [15:0] m_vj [N], m_vk [N];
    logic [3:0]  m_qj [N], m_qk [N];
    int          m_seq[N];
    int          seq_ctr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_sel();
        int s = -1;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 2) begin
`ifdef RS_OLDEST_FIRST_EN
                if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
                if (s < 0) s = i;
`endif
            end
        end
        return s;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        int  f, s;
        bit  hit;
        logic [15:0] vj, vk;
        logic [3:0]  qj, qk;
        if (CLR) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_op[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
                m_qj[i] = '0; m_qk[i] = '0;
            end
            return;
        end
        f   = m_free();
        s   = m_sel();
        hit = cdb_valid && (cdb_tag != 0);
        for (int i = 0; i < N; i++) begin
            case (m_st[i])
                3: if (hit && cdb_tag == 4'(BASE + i)) m_st[i] = 0;
                2: if (s == i && disp_ready) m_st[i] = 3;
                1: begin
                    if (hit && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
                    if (hit && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
                    if (m_qj[i] == 0 && m_qk[i] == 0) m_st[i] = 2;
                end
                default: ;
            endcase
        end
        if (issue_valid && f >= 0) begin
            vj = issue_vj; qj = issue_qj; vk = issue_vk; qk = issue_qk;
            if (hit && qj == cdb_tag) begin vj = cdb_data; qj = 0; end
            if (hit && qk == cdb_tag) begin vk = cdb_data; qk = 0; end
            m_op[f] = issue_op; m_vj[f] = vj; m_vk[f] = vk; m_qj[f] = qj; m_qk[f] = qk;
            m_st[f]  = (qj == 0 && qk == 0) ? 2 : 1;
            m_seq[f] = seq_ctr++;
        end
    endtask

    task automatic compare_model();
        int f = m_free();
        int s = m_sel();
        check("count", 32'(count), 32'(m_count()));
        check("full", 32'(full), 32'(f < 0));
        if (f >= 0) check("issue_tag", 32'(issue_tag), 32'(BASE + f));
        check("disp_valid", 32'(disp_valid), 32'(s >= 0));
        if (s >= 0) begin
            check("disp_tag", 32'(disp_tag), 32'(BASE + s));
            check("disp_op", 32'(disp_op), 32'(m_op[s]));
            check("disp_vj", 32'(disp_vj), 32'(m_vj[s]));
            check("disp_vk", 32'(disp_vk), 32'(m_vk[s]));
        end
    endtask

    task automatic idle();
        CLR = 0; issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
        issue_qj = 0; issue_qk = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        disp_ready = 0;
    endtask

    // Inputs are set at a negedge; this clocks them and checks the result.
    task automatic tick();
        model_update();
        @(negedge CLK);
        compare_model();
        idle();
    endtask

    task automatic do_reset();
        idle(); CLR = 1; tick();
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [3:0] qj,
                         input logic [15:0] vk, input logic [3:0] qk);
        issue_valid = 1; issue_op = op; issue_vj = vj; issue_qj = qj;
        issue_vk = vk; issue_qk = qk;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [15:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    function automatic logic [3:0] pick_q();
        int r = $urandom_range(0, 5);
        if (r <= 2) return 4'd0;
        if (r == 3) return 4'(BASE + $urandom_range(0, N - 1));
        return 4'(8 + $urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_seq[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
            m_qj[i] = 0; m_qk[i] = 0;
        end
        idle();
        @(negedge CLK);
        do_reset();
        do_reset();
        check("rst_issue_tag", 32'(issue_tag), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_disp_fields", {disp_op, disp_vj[12:0], disp_tag, 12'(disp_vk)}, 32'd0);

        // 1: simple ready issue
        issue(3'b001, 16'd5, 4'd0, 16'd7, 4'd0);
        check("t1_issue_tag", 32'(issue_tag), 32'd1);
        tick();
        check("t1_valid", 32'(disp_valid), 32'd1);
        check("t1_vj", 32'(disp_vj), 32'd5);
        check("t1_vk", 32'(disp_vk), 32'd7);
        check("t1_tag", 32'(disp_tag), 32'd1);

        // 2: wake-up by CDB two cycles after issue
        do_reset();
        issue(3'b010, 16'd0, 4'd9, 16'd3, 4'd0); tick();
        tick();
        cdb(4'd9, 16'h1234);
        check("t2_not_yet", 32'(disp_valid), 32'd0);
        tick();
        check("t2_valid", 32'(disp_valid), 32'd1);
        check("t2_vj", 32'(disp_vj), 32'h1234);

        // 3: issue/CDB bypass
        do_reset();
        issue(3'b001, 16'd0, 4'd9, 16'd2, 4'd0);
        cdb(4'd9, 16'hBEEF);
        tick();
        check("t3_valid", 32'(disp_valid), 32'd1);
        check("t3_vj", 32'(disp_vj), 32'hBEEF);

        // 4: fill, overflow issue ignored, free makes room next cycle
        do_reset();
        issue(3'b001, 16'd1, 4'd12, 16'd1, 4'd0); tick();
        issue(3'b001, 16'd2, 4'd12, 16'd2, 4'd0); tick();
        issue(3'b010, 16'd3, 4'd0, 16'd3, 4'd0);  tick();
        check("t4_full", 32'(full), 32'd1);
        check("t4_count", 32'(count), 32'd3);
        issue(3'b001, 16'd4, 4'd0, 16'd4, 4'd0); tick();
        check("t4_ignored", 32'(count), 32'd3);
        check("t4_sel", 32'(disp_tag), 32'd3);
        disp_ready = 1; tick();
        check("t4_exec_valid", 32'(disp_valid), 32'd0);
        cdb(4'd3, 16'd0);
        check("t4_still_full", 32'(full), 32'd1);
        tick();
        check("t4_freed", 32'(full), 32'd0);
        check("t4_count2", 32'(count), 32'd2);
        check("t4_issue_tag", 32'(issue_tag), 32'd3);

        // 5: entry 2 older than re-issued entry 0
        do_reset();
        issue(3'b001, 16'd1, 4'd0, 16'd1, 4'd0); tick();
        issue(3'b001, 16'd2, 4'd12, 16'd2, 4'd0); tick();
        issue(3'b001, 16'd3, 4'd13, 16'd3, 4'd0); disp_ready = 1; tick();
        cdb(4'd1, 16'd0); tick();
        issue(3'b110, 16'd4, 4'd14, 16'd4, 4'd0); tick();
        cdb(4'd13, 16'h0033); tick();
        check("t5_first", 32'(disp_tag), 32'd3);
        cdb(4'd14, 16'h0044); tick();
`ifdef RS_OLDEST_FIRST_EN
        check("t5_pick", 32'(disp_tag), 32'd3);
`else
        check("t5_pick", 32'(disp_tag), 32'd1);
`endif

        // 6: CLR mid-operation
        do_reset();
        issue(3'b001, 16'd1, 4'd0, 16'd1, 4'd0); tick();
        issue(3'b001, 16'd2, 4'd12, 16'd2, 4'd0); disp_ready = 1; tick();
        CLR = 1; disp_ready = 1; cdb(4'd12, 16'h5555); tick();
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", 32'(disp_valid), 32'd0);
        cdb(4'd1, 16'd0); tick();
        cdb(4'd12, 16'h7777); tick();
        check("t6_count2", 32'(count), 32'd0);
        check("t6_valid2", 32'(disp_valid), 32'd0);
        check("t6_issue_tag", 32'(issue_tag), 32'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int r;
            CLR = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1)
                issue(3'($urandom), 16'($urandom), pick_q(), 16'($urandom), pick_q());
            r = $urandom_range(0, 3);
            if (r == 1) cdb(4'(BASE + $urandom_range(0, N - 1)), 16'($urandom));
            else if (r == 2) cdb(4'(8 + $urandom_range(0, 3)), 16'($urandom));
            else if (r == 3) cdb(4'($urandom), 16'($urandom));
            disp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
